// File: rtl/serializer_rr_arbiter.sv
// Round-robin arbiter feeding one wide word stream into a serializer through a registered valid/ready stage.
// Optional SERIALIZER_ARB_TAG_EN adds a registered source-index output on tag_o; otherwise tag_o is tied to zero.
module serializer_rr_arbiter #(
  parameter int num_req_p   = 4,
  parameter int width_p     = 256,
  parameter int burst_max_p = 4,
  localparam int tag_w_lp   = $clog2(num_req_p),
  localparam int cnt_w_lp   = $clog2(burst_max_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           v_i,
  input  logic [num_req_p*width_p-1:0]   data_i,
  output logic [num_req_p-1:0]           yumi_o,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  input  logic                           ready_i,
  output logic [tag_w_lp-1:0]            tag_o,
  output logic [num_req_p-1:0]           grant_o,
  output logic                           busy_o
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q, state_d;
  logic [tag_w_lp-1:0]   owner_q, owner_d;
  logic [tag_w_lp-1:0]   last_q, last_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  logic [width_p-1:0]    data_q, data_d;
  logic                  v_q, v_d;
  logic [num_req_p-1:0]  grant_q, grant_d;
  logic                  busy_q, busy_d;

  logic [tag_w_lp-1:0]   pick;
  logic                  pick_found;
  logic [tag_w_lp-1:0]   scan_idx;
  logic                  load_ok;
  logic                  yumi_fire;
  logic [width_p-1:0]    owner_word;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= tag_w_lp'(num_req_p - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      v_q     <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      v_q     <= v_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  // Scan downward so the requester closest after last_q is assigned last and wins.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan_idx   = '0;
    for (int i = num_req_p; i >= 1; i--) begin
      scan_idx = tag_w_lp'((int'(last_q) + i) % num_req_p);
      if (v_i[scan_idx]) begin
        pick       = scan_idx;
        pick_found = 1'b1;
      end
    end
  end

  // Output process: the consume handshake back to the requesters
  always_comb begin
    load_ok   = !v_q || ready_i;
    yumi_fire = (state_q == GRANT) && v_i[owner_q] && load_ok;
  end

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_yumi
    assign yumi_o[gi] = yumi_fire && (owner_q == tag_w_lp'(gi));
  end

  assign owner_word = data_i[owner_q*width_p +: width_p];

  // Next-state process
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (yumi_fire) begin
          if (cnt_q == cnt_w_lp'(burst_max_p - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end else if (load_ok) begin
          // Owner ran dry before its burst quota: hand the slot back early.
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    v_d    = v_q;
    if (yumi_fire) begin
      data_d = owner_word;
      v_d    = 1'b1;
    end else if (ready_i) begin
      v_d = 1'b0;
    end
    grant_d = (state_d == GRANT) ? (num_req_p'(1) << owner_d) : '0;
    busy_d  = (state_d == GRANT) || v_d;
  end

`ifdef SERIALIZER_ARB_TAG_EN
  logic [tag_w_lp-1:0] tag_q, tag_d;

  always_comb begin
    tag_d = yumi_fire ? owner_q : tag_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) tag_q <= '0;
    else         tag_q <= tag_d;
  end

  assign tag_o = tag_q;
`else
  assign tag_o = '0;
`endif

  assign v_o     = v_q;
  assign data_o  = data_q;
  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule
